// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            valid/ready requesters, with registered operands and result.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int N  = 32,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [N-1:0]  req0_b,
    input  logic [SW-1:0] req0_s,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_a,
    input  logic [N-1:0]  req1_b,
    input  logic [SW-1:0] req1_s,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [N-1:0]  rsp0_z,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [N-1:0]  rsp1_z,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [SW-1:0] alu_s,
    input  logic [N-1:0]  alu_z,
    output logic [1:0]    gnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prio;
    logic          w_prio_nxt;
    logic          r_owner;
    logic          w_owner_nxt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [SW-1:0] r_s;
    logic [N-1:0]  r_z;

    logic          w_any_valid;
    logic          w_win1;
    logic          w_accept;
    logic          w_rsp_ready;

    // Requester 1 wins when alone, or on a tie when prio points at it.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_win1      = req1_valid & (~req0_valid | r_prio);
    assign w_accept    = (r_state == ST_IDLE) & ~rst & w_any_valid;
    assign req0_ready  = w_accept & ~w_win1;
    assign req1_ready  = w_accept & w_win1;
    assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                    w_owner_nxt = w_win1;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = ~r_owner;
                    w_owner_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_owner <= w_owner_nxt;
            // Operands are frozen at acceptance so later input changes cannot disturb the ALU.
            if (w_accept) begin
                r_a <= w_win1 ? req1_a : req0_a;
                r_b <= w_win1 ? req1_b : req0_b;
                r_s <= w_win1 ? req1_s : req0_s;
            end
            if (r_state == ST_EXEC) begin
                r_z <= alu_z;
            end
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_s      = r_s;
    assign rsp0_z     = r_z;
    assign rsp1_z     = r_z;
    assign rsp0_valid = (r_state == ST_RESP) & ~r_owner;
    assign rsp1_valid = (r_state == ST_RESP) &  r_owner;
    assign gnt        = (r_state == ST_IDLE) ? 2'b00 : {r_owner, ~r_owner};

endmodule
`default_nettype wire
